// File: rtl/e_mdu.sv
`timescale 1ns/1ps
// e_mdu: E-stage multiply/divide unit that owns HI/LO; results are held in shadow registers and commit after a fixed busy period.
// Defining MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU (ops 9-12) as multiply-latency starts.
module e_mdu #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             E_Start,
  input  logic [3:0]       E_MDUOp,
  input  logic [WIDTH-1:0] E_A,
  input  logic [WIDTH-1:0] E_B,
  input  logic             E_Req,
  output logic             E_Busy,
  output logic [WIDTH-1:0] E_HI,
  output logic [WIDTH-1:0] E_LO,
  output logic [WIDTH-1:0] E_Result
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } mdu_op_e;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           state;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] shi_q, shi_d, slo_q, slo_d;

  // The busy counter doubles as the state register: zero is IDLE.
  assign state  = (count_q == '0) ? S_IDLE : S_RUN;
  assign E_Busy = (state == S_RUN);
  assign E_HI   = hi_q;
  assign E_LO   = lo_q;

  // Low 2W bits of the sign-extended product equal the signed product.
  logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
  assign a_sx   = {{WIDTH{E_A[WIDTH-1]}}, E_A};
  assign b_sx   = {{WIDTH{E_B[WIDTH-1]}}, E_B};
  assign a_zx   = {{WIDTH{1'b0}}, E_A};
  assign b_zx   = {{WIDTH{1'b0}}, E_B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, uden, mden, uq, ur, mq, mr, sq, sr;
  assign a_neg = E_A[WIDTH-1];
  assign b_neg = E_B[WIDTH-1];
  assign a_mag = a_neg ? -E_A : E_A;
  assign b_mag = b_neg ? -E_B : E_B;
  // Divisor forced non-zero; the B=0 case is routed to the old HI/LO below.
  assign uden  = (E_B == '0)   ? WIDTH'(1) : E_B;
  assign mden  = (b_mag == '0) ? WIDTH'(1) : b_mag;
  assign uq    = E_A / uden;
  assign ur    = E_A % uden;
  assign mq    = a_mag / mden;
  assign mr    = a_mag % mden;
  // Sign-magnitude divide: MIN/-1 falls out as quotient MIN, remainder 0.
  assign sq    = (a_neg ^ b_neg) ? -mq : mq;
  assign sr    = a_neg ? -mr : mr;

  always_comb begin
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    shi_d   = shi_q;
    slo_d   = slo_q;
    if (state == S_RUN) begin
      count_d = count_q - CW'(1);
      if (count_q == CW'(1)) begin
        hi_d = shi_q;
        lo_d = slo_q;
      end
    end else if (!E_Req) begin
      case (E_MDUOp)
        OP_MULT: if (E_Start) begin
          count_d        = MULT_CNT;
          {shi_d, slo_d} = prod_s;
        end
        OP_MULTU: if (E_Start) begin
          count_d        = MULT_CNT;
          {shi_d, slo_d} = prod_u;
        end
        OP_DIV: if (E_Start) begin
          count_d        = DIV_CNT;
          {shi_d, slo_d} = (E_B == '0) ? {hi_q, lo_q} : {sr, sq};
        end
        OP_DIVU: if (E_Start) begin
          count_d        = DIV_CNT;
          {shi_d, slo_d} = (E_B == '0) ? {hi_q, lo_q} : {ur, uq};
        end
`ifdef MDU_MADD_EN
        OP_MADD: if (E_Start) begin
          count_d        = MULT_CNT;
          {shi_d, slo_d} = {hi_q, lo_q} + prod_s;
        end
        OP_MADDU: if (E_Start) begin
          count_d        = MULT_CNT;
          {shi_d, slo_d} = {hi_q, lo_q} + prod_u;
        end
        OP_MSUB: if (E_Start) begin
          count_d        = MULT_CNT;
          {shi_d, slo_d} = {hi_q, lo_q} - prod_s;
        end
        OP_MSUBU: if (E_Start) begin
          count_d        = MULT_CNT;
          {shi_d, slo_d} = {hi_q, lo_q} - prod_u;
        end
`endif
        OP_MTHI: hi_d = E_A;
        OP_MTLO: lo_d = E_A;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (E_MDUOp)
      OP_MFHI: E_Result = hi_q;
      OP_MFLO: E_Result = lo_q;
      default: E_Result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      shi_q   <= '0;
      slo_q   <= '0;
    end else begin
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      shi_q   <= shi_d;
      slo_q   <= slo_d;
    end
  end

endmodule
